button_ctrl: RTL

Game input controller between the per-button `button_sync` synchronizers and the game state machine. Each synchronized button gets debounced, press edge detection and optional auto-repeat (delayed auto-shift). Pending commands from all buttons go through a fixed-priority arbiter. The result leaves as a single valid/ready command stream, so the game logic consumes at most one move per handshake.

---
 rtl/input_pkg.sv | 23 ++
 rtl/btn_channel.sv | 116 +++++++++++
 rtl/button_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/input_pkg.sv
// Shared types for the game input controller: button indices,
// channel FSM states and the command bundle handed to game logic.
package input_pkg;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_ROTATE = 2;
  localparam int BTN_DROP   = 3;

  localparam int CMD_ID_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DAS,
    ST_ARR
  } ch_state_t;

  typedef struct packed {
    logic [CMD_ID_W-1:0] id;
    logic                rpt;
  } cmd_t;

endpackage

// File: rtl/btn_channel.sv
// One button lane: debounce, press edge detection and
// delayed auto-shift repeat event generation.
module btn_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DAS_CYCLES      = 4000000,
  parameter int ARR_CYCLES      = 1250000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sync,
  output logic stable,
  output logic evt,
  output logic evt_rep
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TM_MAX = (DAS_CYCLES > ARR_CYCLES) ?
                          DAS_CYCLES : ARR_CYCLES;
  localparam int TM_W   = $clog2(TM_MAX) + 1;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DAS_LAST = TM_W'(DAS_CYCLES - 1);
  localparam logic [TM_W-1:0] ARR_LAST = TM_W'(ARR_CYCLES - 1);

  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;
  ch_state_t       r_state;
  ch_state_t       w_nxt_state;
  logic [TM_W-1:0] r_tmr;
  logic [TM_W-1:0] w_nxt_tmr;
  logic            w_diff;
  logic            w_accept;
  logic            w_rise;
  logic            w_fall;

  assign w_diff   = btn_sync ^ r_stable;
  assign w_accept = w_diff && (r_db_cnt == DB_LAST);
  // Edges are taken at acceptance so the FSM moves with stable.
  assign w_rise   = w_accept && btn_sync;
  assign w_fall   = w_accept && !btn_sync;
  assign stable   = r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else if (!w_diff) begin
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_stable <= btn_sync;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_tmr   <= w_nxt_tmr;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tmr   = r_tmr;
    evt         = 1'b0;
    evt_rep     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_nxt_state = ST_DAS;
          w_nxt_tmr   = '0;
          evt         = 1'b1;
        end
      end
      ST_DAS: begin
        if (w_fall) begin
          w_nxt_state = ST_IDLE;
          w_nxt_tmr   = '0;
        end else if (REPEAT_EN && r_tmr == DAS_LAST) begin
          w_nxt_state = ST_ARR;
          w_nxt_tmr   = '0;
          evt         = 1'b1;
          evt_rep     = 1'b1;
        end else if (r_tmr != DAS_LAST) begin
          // Non-repeating buttons park at terminal count.
          w_nxt_tmr = r_tmr + 1'b1;
        end
      end
      ST_ARR: begin
        if (w_fall) begin
          w_nxt_state = ST_IDLE;
          w_nxt_tmr   = '0;
        end else if (r_tmr == ARR_LAST) begin
          w_nxt_tmr = '0;
          evt       = 1'b1;
          evt_rep   = 1'b1;
        end else begin
          w_nxt_tmr = r_tmr + 1'b1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_tmr   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_ctrl.sv
// Button input controller: per-button channels, pending latches,
// fixed-priority arbiter and a valid/ready command register.
module button_ctrl
  import input_pkg::*;
#(
  parameter int           NUM_BTN         = 4,
  parameter int           DEBOUNCE_CYCLES = 250000,
  parameter int           DAS_CYCLES      = 4000000,
  parameter int           ARR_CYCLES      = 1250000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = 4'b0011
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_sync,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [$clog2(NUM_BTN)-1:0] cmd_id,
  output logic                       cmd_repeat,
  output logic [NUM_BTN-1:0]         btn_stable
);

  localparam int ID_W = $clog2(NUM_BTN);

  logic [NUM_BTN-1:0]  w_evt;
  logic [NUM_BTN-1:0]  w_evt_rep;
  logic [NUM_BTN-1:0]  r_pend;
  logic [NUM_BTN-1:0]  r_pend_rep;
  logic [NUM_BTN-1:0]  w_gnt;
  logic                w_can;
  logic                w_any;
  cmd_t                w_nxt_cmd;
  cmd_t                r_cmd;
  logic                r_valid;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DAS_CYCLES      (DAS_CYCLES),
      .ARR_CYCLES      (ARR_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[g])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_sync (btn_sync[g]),
      .stable   (btn_stable[g]),
      .evt      (w_evt[g]),
      .evt_rep  (w_evt_rep[g])
    );
  end

  assign w_can = !r_valid || cmd_ready;
  assign w_any = |r_pend;

  // Scan high to low so the lowest pending index wins.
  always_comb begin
    w_gnt     = '0;
    w_nxt_cmd = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_gnt         = '0;
        w_gnt[i]      = 1'b1;
        w_nxt_cmd.id  = CMD_ID_W'(i);
        w_nxt_cmd.rpt = r_pend_rep[i];
      end
    end
    if (!w_can) w_gnt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_pend_rep <= '0;
    end else begin
      r_pend     <= (r_pend & ~w_gnt) | w_evt;
      r_pend_rep <= (r_pend_rep & ~w_evt) | (w_evt & w_evt_rep);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_cmd   <= '0;
    end else if (w_can && w_any) begin
      r_valid <= 1'b1;
      r_cmd   <= w_nxt_cmd;
    end else if (cmd_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign cmd_valid  = r_valid;
  assign cmd_id     = ID_W'(r_cmd.id);
  assign cmd_repeat = r_cmd.rpt;

endmodule
